// File: rtl/temp_pkg.sv
// Shared constants and state encoding for the temperature converter.
package temp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int MULT         = 9;   // degF = degC * 9/5 + 32
  localparam int DIVISOR_BASE = 5;   // scaled by 2**FRAC_BITS at the divider
  localparam int F_OFFSET     = 32;
  localparam int DIV_STEPS    = 20;  // one quotient bit per cycle
  localparam int PROD_W       = 20;  // width of 9 * 16-bit value, no overflow

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: one quotient bit per cycle, MSB first.
// done is high during the cycle that performs the final step, so the
// quotient is complete on the clock edge that ends that cycle.
module seq_divider
  import temp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PROD_W-1:0] dividend,
  input  logic [6:0]        divisor,
  output logic [PROD_W-1:0] quotient,
  output logic              done
);

  logic [PROD_W-1:0] dvd;
  logic [6:0]        rem;
  logic [4:0]        cnt;
  logic              running;
  logic [7:0]        trial;
  logic              ge;
  logic [6:0]        diff;

  // Trial subtraction of the divisor from the partial remainder plus next bit
  always_comb begin
    trial = {rem, dvd[PROD_W-1]};
    ge    = (trial >= {1'b0, divisor});
    diff  = 7'(trial - {1'b0, divisor});
  end

  assign done = running && (cnt == 5'd0);

  // Load on start, then shift one quotient bit per cycle until the counter hits zero
  always_ff @(posedge clk) begin
    if (reset) begin
      dvd      <= '0;
      rem      <= '0;
      quotient <= '0;
      cnt      <= '0;
      running  <= 1'b0;
    end else if (start) begin
      dvd      <= dividend;
      rem      <= '0;
      quotient <= '0;
      cnt      <= 5'(DIV_STEPS - 1);
      running  <= 1'b1;
    end else if (running) begin
      dvd      <= dvd << 1;
      rem      <= ge ? diff : trial[6:0];
      quotient <= {quotient[PROD_W-2:0], ge};
      if (cnt == 5'd0) running <= 1'b0;
      else             cnt     <= cnt - 5'd1;
    end
  end

endmodule

// File: rtl/temp_converter.sv
// Converts a 1/16 degC reading into integer degC and degF.
// Fixed 23-cycle latency: capture, multiply, 20 divide steps, output.
module temp_converter
  import temp_pkg::*;
#(
  parameter int FRAC_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_en,
  input  logic [15:0] val_in,
  output logic [15:0] c_out,
  output logic [15:0] f_out,
  output logic        valid,
  output logic        busy
);

  localparam logic [6:0] DIVISOR = 7'(DIVISOR_BASE << FRAC_BITS);

  state_t            state;
  logic [15:0]       v;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] quotient;
  logic              div_start;
  logic              div_done;

  // Quotient is at most 7372, so dropping the upper bits loses nothing
  function automatic logic [15:0] to_fahrenheit(input logic [PROD_W-1:0] q);
    return 16'(q + PROD_W'(F_OFFSET));
  endfunction

  // 9*v built as shift-and-add; 20 bits hold the full product of a 16-bit value
  always_comb begin
    prod = ({4'b0, v} << 3) + {4'b0, v};
  end

  assign div_start = (state == MUL);

  seq_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (prod),
    .divisor  (DIVISOR),
    .quotient (quotient),
    .done     (div_done)
  );

  // Conversion sequencer with registered outputs; reset aborts any conversion
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      c_out <= '0;
      f_out <= 16'(F_OFFSET);
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_en) begin
            v     <= val_in;
            busy  <= 1'b1;
            state <= MUL;
          end
        end
        MUL: begin
          state <= DIV;
        end
        DIV: begin
          if (div_done) state <= DONE;
        end
        DONE: begin
          c_out <= v >> FRAC_BITS;
          f_out <= to_fahrenheit(quotient);
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_converter.sv
// Self-checking bench for temp_converter: scoreboard of expected results
// pushed at stimulus time, popped by a monitor on every valid pulse.
module tb_temp_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_en;
  logic [15:0] val_in;
  logic [15:0] c_out;
  logic [15:0] f_out;
  logic        valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] v;
    logic [15:0] c;
    logic [15:0] f;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  temp_converter #(.FRAC_BITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .val_in    (val_in),
    .c_out     (c_out),
    .f_out     (f_out),
    .valid     (valid),
    .busy      (busy)
  );

  // Reference: degC = v/16, degF = (v*9)/80 + 32, both truncated
  function automatic exp_t model(input logic [15:0] v);
    exp_t e;
    int unsigned t;
    t   = v;
    e.v = v;
    e.c = 16'(t / 16);
    e.f = 16'((t * 9) / 80 + 32);
    return e;
  endfunction

  task automatic push_exp(input logic [15:0] v);
    sb.push_back(model(v));
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got valid=1 with c_out=%0d f_out=%0d, want no pulse", c_out, f_out);
      end else begin
        e = sb.pop_front();
        if (c_out !== e.c) begin
          errors++;
          $display("FAIL c_out(v=%h): got %0d, want %0d", e.v, c_out, e.c);
        end
        checks++;
        if (f_out !== e.f) begin
          errors++;
          $display("FAIL f_out(v=%h): got %0d, want %0d", e.v, f_out, e.f);
        end
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_with_valid: got %b, want 0", busy);
        end
      end
    end
  end

  // Single conversion: checks 23-edge latency and busy held until valid
  task automatic run_conv(input logic [15:0] v, input string name);
    int n;
    bit busy_ok;
    @(negedge clk);
    sample_en = 1'b1;
    val_in    = v;
    push_exp(v);
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    n = 1;
    busy_ok = 1'b1;
    while (!valid && n < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n !== 23) begin
      errors++;
      $display("FAIL %s latency: got edge %0d, want edge 23", name, n);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL %s busy: got 0 before valid, want 1 from edge 1 to 22", name);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    sample_en = 1'b1;
    val_in    = 16'h0190;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (c_out !== 16'd0) begin errors++; $display("FAIL reset c_out: got %0d, want 0", c_out); end
    checks++;
    if (f_out !== 16'd32) begin errors++; $display("FAIL reset f_out: got %0d, want 32", f_out); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b, want 0", valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy (priority over sample_en): got %b, want 0", busy); end
    @(negedge clk);
    sample_en = 1'b0;
    reset     = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_basic();
    run_conv(16'h0190, "basic_25C");
    run_conv(16'h0123, "basic_0123");
    run_conv(16'($urandom_range(0, 65535)), "basic_rand");
  endtask

  task automatic test_truncation();
    run_conv(16'h0000, "zero");
    run_conv(16'h0008, "half_degree");
    run_conv(16'h000F, "just_below_1C");
  endtask

  task automatic test_max();
    run_conv(16'hFFFF, "max");
  endtask

  // Input changes while busy must not disturb the captured value
  task automatic test_ignore_changes();
    int first_v;
    int second_v;
    first_v  = -1;
    second_v = -1;
    @(negedge clk);
    sample_en = 1'b1;
    val_in    = 16'h0190;
    push_exp(16'h0190);
    push_exp(16'h0500);
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk);
      #1;
      if (n == 4)  val_in = 16'h0500;
      if (n == 24) sample_en = 1'b0;
      if (valid) begin
        if (first_v < 0) first_v = n;
        else if (second_v < 0) second_v = n;
      end
    end
    checks++;
    if (first_v !== 23) begin errors++; $display("FAIL ignore first_valid: got edge %0d, want 23", first_v); end
    checks++;
    if (second_v !== 46) begin errors++; $display("FAIL ignore second_valid: got edge %0d, want 46", second_v); end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    sample_en = 1'b1;
    val_in    = 16'h0190;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) sample_en = 1'b0;
      if (n == 9) reset = 1'b1;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort busy: got %b, want 0", busy); end
    checks++;
    if (c_out !== 16'd0) begin errors++; $display("FAIL abort c_out: got %0d, want 0", c_out); end
    checks++;
    if (f_out !== 16'd32) begin errors++; $display("FAIL abort f_out: got %0d, want 32", f_out); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL abort valid: got %b, want 0", valid); end
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(posedge clk);
    run_conv(16'h0500, "after_abort");
  endtask

  // sample_en held high: captures at edges 1, 24, 47 -> valid at 23, 46, 69
  task automatic test_back_to_back();
    logic [15:0] vals[3];
    int edges[3];
    int k;
    vals[0] = 16'h1234;
    vals[1] = 16'h0ABC;
    vals[2] = 16'h7FFF;
    k = 0;
    for (int i = 0; i < 3; i++) edges[i] = -1;
    @(negedge clk);
    sample_en = 1'b1;
    val_in    = vals[0];
    push_exp(vals[0]);
    for (int n = 1; n <= 75; n++) begin
      @(posedge clk);
      #1;
      if (n == 47) sample_en = 1'b0;
      if (valid && k < 3) begin
        edges[k] = n;
        k++;
        if (k < 3) begin
          val_in = vals[k];
          push_exp(vals[k]);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (edges[i] !== 23 * (i + 1)) begin
        errors++;
        $display("FAIL b2b valid_%0d: got edge %0d, want %0d", i, edges[i], 23 * (i + 1));
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    sample_en = 1'b0;
    val_in    = '0;
    test_reset();
    test_basic();
    test_truncation();
    test_max();
    test_ignore_changes();
    test_reset_abort();
    test_back_to_back();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/temp_converter.md
TEMP_CONVERTER -- requirements
Module: temp_converter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, listed first as "clk" and "reset".
REQ-002 Parameter FRAC_BITS, default 4, SHALL give the number of fractional bits in val_in; only 4 is verified.
REQ-003 clk  in  1  system clock, at least 25 MHz.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 sample_en  in  1  level-sensitive request; samples val_in whenever the block is idle.
REQ-006 val_in  in  16  unsigned temperature in 1/16 degC units.
REQ-007 c_out  out  16  integer degC, binary, zero-extended; feeds the display's celsius input.
REQ-008 f_out  out  16  integer degF, binary; feeds the display's farenheit input.
REQ-009 valid  out  1  one-cycle pulse when c_out/f_out update.
REQ-010 busy  out  1  high from the cycle after capture until valid.

Function
REQ-011 States SHALL be IDLE, MUL, DIV, DONE.
REQ-012 In IDLE with sample_en=1 at a rising edge, the block SHALL capture val_in into an internal register and go to MUL; it SHALL stay in IDLE otherwise.
REQ-013 MUL (1 cycle) SHALL form the 20-bit product P = (v<<3)+v = 9*v, with no truncation.
REQ-014 DIV SHALL run exactly 20 cycles of restoring division of P by 80 (5<<FRAC_BITS), 1 quotient bit per cycle, MSB first; a 5-bit step counter SHALL count 19 down to 0.
REQ-015 DONE (1 cycle) SHALL register c_out = v>>4 (truncated) and f_out = quotient+32 (truncated); it SHALL pulse valid and return to IDLE.
REQ-016 Latency SHALL be fixed: counting the capture edge as edge 1, outputs and valid change on edge 23.
REQ-017 After that valid cycle, if sample_en is still high, the next capture SHALL occur on the following edge (back-to-back period 23 cycles).
REQ-018 val_in and sample_en changes while busy SHALL be ignored; results always reflect the captured value.
REQ-019 c_out and f_out SHALL hold their last values between updates and SHALL never show partial results.
REQ-020 Range: for val_in=0xFFFF, f_out=7404 and c_out=4095, both <=9999, so downstream BCD never saturates.
REQ-021 busy SHALL be 0 in IDLE and 1 in MUL, DIV and DONE; valid and busy SHALL never be 1 in the same cycle except in DONE.

Reset
REQ-022 reset SHALL force state=IDLE, c_out=0, f_out=32, valid=0, busy=0, and clear the counter, quotient and remainder.
REQ-023 reset asserted mid-MUL or mid-DIV SHALL abort the conversion with no valid pulse; reset has priority over sample_en.

Structure
REQ-024 A shared package temp_pkg SHALL hold the state enum, MULT=9, DIVISOR_BASE=5, F_OFFSET=32, DIV_STEPS=20 and PROD_W=20.
REQ-025 Restoring division SHALL be one sub-module, seq_divider, with start/done handshake, a 20-bit dividend, a 7-bit divisor and a 20-bit quotient; temp_converter owns the FSM and output registers.

Verification
REQ-026 Reset, then sample_en=1 with val_in=0x0190 -> valid on edge 23: c_out=25, f_out=77, busy high for edges 2..22.
REQ-027 val_in=0x0000 -> c_out=0, f_out=32; val_in=0x0008 (0.5 degC) -> c_out=0, f_out=32 (truncation).
REQ-028 val_in=0xFFFF -> c_out=4095, f_out=7404.
REQ-029 Capture 0x0190, change val_in to 0x0500 on edge 5 -> result 25/77; the next conversion returns c_out=80, f_out=176, 23 cycles later.
REQ-030 Assert reset on edge 10 of a conversion -> no valid pulse, outputs return to 0/32, busy=0 on the next cycle; a fresh conversion then completes normally.
REQ-031 Hold sample_en=1 continuously -> valid pulses exactly every 23 cycles.
